// File: rtl/vote_ballot_collector.sv
// -----------------------------------------------------------------------------
// vote_ballot_collector
//
// Sequential front end for the 3-voter vote counter. A round is opened with
// `start`, one ballot per voter is collected over a valid/ack handshake, the
// assembled vote vector is presented to the external counter for one cycle,
// and the counter's one-hot answer is decoded, cross-checked and published.
//
// Parameters
//   TIMEOUT       cycles in COLLECT without an accepted ballot before the
//                 round closes on its own (1..255)
//
// Ports
//   clk           in   1  rising-edge clock
//   rst_n         in   1  asynchronous active-low reset
//   start         in   1  open a new round (honoured only in IDLE)
//   ballot_valid  in   1  ballot offered this cycle
//   ballot_id     in   2  voter index 0..2 (3 is illegal)
//   ballot_yes    in   1  1 = yes vote
//   ballot_ack    out  1  pulse the cycle after a ballot is consumed
//   V             out  3  vote vector to counter, V[i] = voter i yes
//   v_valid       out  1  V is being presented to the counter
//   R             in   4  one-hot yes count from the counter
//   tally         out  2  decoded yes count, held until next start
//   majority      out  1  tally >= 2, held until next start
//   result_valid  out  1  one-cycle pulse when the round result is ready
//   err_dup       out  1  pulse: duplicate voter or id 3 ballot rejected
//   err_onehot    out  1  sticky per round: counter answer inconsistent
//   busy          out  1  a round is in progress
// -----------------------------------------------------------------------------
module vote_ballot_collector #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       ballot_valid,
    input  logic [1:0] ballot_id,
    input  logic       ballot_yes,
    output logic       ballot_ack,
    output logic [2:0] V,
    output logic       v_valid,
    input  logic [3:0] R,
    output logic [1:0] tally,
    output logic       majority,
    output logic       result_valid,
    output logic       err_dup,
    output logic       err_onehot,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] mask_q;
    logic [2:0] mask_d;
    logic [7:0] timer_q;

    logic       consume;
    logic       accept;
    logic [3:0] taken;
    logic [2:0] sel;
    logic [1:0] r_idx;
    logic [2:0] r_ones;
    logic [1:0] v_ones;
    logic       r_bad;
    logic [1:0] tally_new;

    // Id 3 is mapped onto an always-set mask bit, so an illegal id and a
    // repeated voter fall into the same "reject" path.
    assign taken   = {1'b1, mask_q};
    assign sel     = 3'b001 << ballot_id;
    assign consume = (state_q == S_COLLECT) && ballot_valid;
    assign accept  = consume && !taken[ballot_id];
    assign mask_d  = accept ? (mask_q | sel) : mask_q;

    assign v_valid      = (state_q == S_PRESENT);
    assign result_valid = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);

    // Decode and cross-check the counter's answer against our own popcount.
    // NOTE: every signal written in always_comb gets a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        r_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (R[k]) begin
                r_idx = 2'(k);
            end
        end
        r_ones    = 3'($countones(R));
        v_ones    = 2'($countones(V));
        r_bad     = (r_ones != 3'd1) || (r_idx != v_ones);
        tally_new = r_bad ? v_ones : r_idx;
    end

    // Next-state logic. An acceptance resets the timer, so the timeout only
    // fires in a cycle with no accepted ballot; a third acceptance always
    // closes the round regardless of the timer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if ((accept && mask_d == 3'b111) || (!accept && timer_q == TIMER_LAST)) begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= 3'b000;
            timer_q    <= 8'd0;
            V          <= 3'b000;
            ballot_ack <= 1'b0;
            err_dup    <= 1'b0;
            tally      <= 2'd0;
            majority   <= 1'b0;
            err_onehot <= 1'b0;
        end else begin
            // Every consumed ballot is acknowledged; rejects also flag err_dup.
            ballot_ack <= consume;
            err_dup    <= consume && !accept;

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q     <= 3'b000;
                        timer_q    <= 8'd0;
                        V          <= 3'b000;
                        tally      <= 2'd0;
                        majority   <= 1'b0;
                        err_onehot <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        V       <= ballot_yes ? (V | sel) : (V & ~sel);
                        mask_q  <= mask_d;
                        timer_q <= 8'd0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_PRESENT: begin
                    tally    <= tally_new;
                    majority <= (tally_new >= 2'd2);
                    if (r_bad) begin
                        err_onehot <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_ballot_collector.sv
// -----------------------------------------------------------------------------
// tb_vote_ballot_collector
//
// Self-checking bench for vote_ballot_collector. Each round's expected result
// is pushed to a scoreboard queue when the round is started and popped when
// result_valid appears. The counter on R is a bench model (one-hot of the
// popcount of V) that can be overridden with a fixed bad value.
// -----------------------------------------------------------------------------
module tb_vote_ballot_collector;

    localparam int unsigned TIMEOUT = 4;

    typedef struct packed {
        logic [2:0] v;
        logic [1:0] tally;
        logic       maj;
        logic       err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ballot_valid;
    logic [1:0] ballot_id;
    logic       ballot_yes;
    logic       ballot_ack;
    logic [2:0] V;
    logic       v_valid;
    logic [3:0] R;
    logic [1:0] tally;
    logic       majority;
    logic       result_valid;
    logic       err_dup;
    logic       err_onehot;
    logic       busy;

    logic       r_mode;
    logic [3:0] r_force;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    vote_ballot_collector #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ballot_valid (ballot_valid),
        .ballot_id    (ballot_id),
        .ballot_yes   (ballot_yes),
        .ballot_ack   (ballot_ack),
        .V            (V),
        .v_valid      (v_valid),
        .R            (R),
        .tally        (tally),
        .majority     (majority),
        .result_valid (result_valid),
        .err_dup      (err_dup),
        .err_onehot   (err_onehot),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Counter stub: one-hot of the number of yes votes, or a forced value.
    always_comb begin
        R = 4'b0001 << $countones(V);
        if (r_mode) begin
            R = r_force;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_ballot(input logic [1:0] id, input logic yes);
        ballot_valid = 1'b1;
        ballot_id    = id;
        ballot_yes   = yes;
    endtask

    // Waits (bounded) for result_valid; reports the observed result and how
    // many cycles it took.
    task automatic collect(output bit found, output res_t obs, output int waited);
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 40) begin
            if (result_valid) begin
                found = 1'b1;
            end else begin
                tick();
                waited++;
            end
        end
        obs = {V, tally, majority, err_onehot};
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        int          rv_seen;
        rst_n = 1'b0;
        start = 1'b0;
        ballot_valid = 1'b0;
        ballot_id = 2'd0;
        ballot_yes = 1'b0;
        r_mode = 1'b0;
        r_force = 4'b0000;
        #12;
        outs = {ballot_ack, V, v_valid, tally, majority, result_valid, err_dup, err_onehot, busy, 4'b0};
        checks++;
        if (outs !== 16'd0) begin
            errors++;
            $display("FAIL reset_initial outputs got=%h want=0", outs);
        end
        rst_n = 1'b1;
        tick();
        start_round();
        drive_ballot(2'd0, 1'b1);
        tick();
        drive_ballot(2'd2, 1'b1);
        tick();
        ballot_valid = 1'b0;
        checks++;
        if (V !== 3'b101 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup V=%b busy=%b want V=101 busy=1", V, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {ballot_ack, V, v_valid, tally, majority, result_valid, err_dup, err_onehot, busy, 4'b0};
        checks++;
        if (outs !== 16'd0) begin
            errors++;
            $display("FAIL reset_async outputs got=%h want=0", outs);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b want 0", busy);
        end
        rv_seen = 0;
        repeat (10) begin
            tick();
            rv_seen += int'(result_valid);
        end
        checks++;
        if (rv_seen != 0) begin
            errors++;
            $display("FAIL reset_no_result result_valid pulses=%0d want 0", rv_seen);
        end
    endtask

    task automatic test_idle_ignore();
        int acks = 0;
        int dups = 0;
        int busys = 0;
        drive_ballot(2'd0, 1'b1);
        repeat (3) begin
            tick();
            acks  += int'(ballot_ack);
            dups  += int'(err_dup);
            busys += int'(busy);
        end
        ballot_valid = 1'b0;
        checks++;
        if (acks != 0 || dups != 0 || busys != 0) begin
            errors++;
            $display("FAIL idle_ignore acks=%0d dups=%0d busy=%0d want 0/0/0", acks, dups, busys);
        end
    endtask

    task automatic test_full_round();
        logic [1:0] ids[3]  = '{2'd0, 2'd1, 2'd2};
        logic       yess[3] = '{1'b1, 1'b0, 1'b1};
        int   acks = 0;
        bit   found;
        res_t obs;
        res_t exp;
        int   waited;
        start_round();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy busy=%b want 1", busy);
        end
        sb.push_back('{3'b101, 2'd2, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            drive_ballot(ids[i], yess[i]);
            tick();
            acks += int'(ballot_ack);
        end
        ballot_valid = 1'b0;
        checks++;
        if (acks != 3 || v_valid !== 1'b1 || V !== 3'b101) begin
            errors++;
            $display("FAIL full_present acks=%0d v_valid=%b V=%b want 3/1/101", acks, v_valid, V);
        end
        collect(found, obs, waited);
        exp = sb.pop_front();
        checks++;
        if (!found || obs !== exp || waited != 1) begin
            errors++;
            $display("FAIL full_result found=%0d got=%h want=%h waited=%0d want 1", found, obs, exp, waited);
        end
        tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_pulse result_valid=%b busy=%b want 0/0", result_valid, busy);
        end
        start = 1'b0;
        repeat (5) tick();
        checks++;
        if (V !== 3'b101 || tally !== 2'd2 || majority !== 1'b1) begin
            errors++;
            $display("FAIL full_hold V=%b tally=%0d maj=%b want 101/2/1", V, tally, majority);
        end
    endtask

    task automatic test_duplicate();
        logic [1:0] ids[3]  = '{2'd1, 2'd1, 2'd3};
        logic       yess[3] = '{1'b1, 1'b0, 1'b1};
        logic       dup_want[3] = '{1'b0, 1'b1, 1'b1};
        int   acks = 0;
        int   dup_bad = 0;
        int   dups = 0;
        bit   found;
        res_t obs;
        res_t exp;
        int   waited;
        start_round();
        sb.push_back('{3'b010, 2'd1, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            drive_ballot(ids[i], yess[i]);
            tick();
            acks += int'(ballot_ack);
            dups += int'(err_dup);
            if (err_dup !== dup_want[i]) dup_bad++;
        end
        ballot_valid = 1'b0;
        tick();
        dups += int'(err_dup);
        checks++;
        if (acks != 3 || dups != 2 || dup_bad != 0) begin
            errors++;
            $display("FAIL dup_pulses acks=%0d dups=%0d misplaced=%0d want 3/2/0", acks, dups, dup_bad);
        end
        checks++;
        if (V !== 3'b010) begin
            errors++;
            $display("FAIL dup_keep V=%b want 010", V);
        end
        collect(found, obs, waited);
        exp = sb.pop_front();
        checks++;
        if (!found || obs !== exp) begin
            errors++;
            $display("FAIL dup_result found=%0d got=%h want=%h", found, obs, exp);
        end
        tick();
    endtask

    task automatic test_timeout();
        int   n = 0;
        bit   found;
        res_t obs;
        res_t exp;
        int   waited;
        start_round();
        sb.push_back('{3'b100, 2'd1, 1'b0, 1'b0});
        drive_ballot(2'd2, 1'b1);
        tick();
        ballot_valid = 1'b0;
        while (!v_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL timeout_latency cycles=%0d want 4", n);
        end
        collect(found, obs, waited);
        exp = sb.pop_front();
        checks++;
        if (!found || obs !== exp) begin
            errors++;
            $display("FAIL timeout_result found=%0d got=%h want=%h", found, obs, exp);
        end
        tick();
    endtask

    task automatic test_bad_counter();
        bit   found;
        res_t obs;
        res_t exp;
        int   waited;
        r_mode  = 1'b1;
        r_force = 4'b0110;
        start_round();
        sb.push_back('{3'b111, 2'd3, 1'b1, 1'b1});
        for (int i = 0; i < 3; i++) begin
            drive_ballot(2'(i), 1'b1);
            tick();
        end
        ballot_valid = 1'b0;
        collect(found, obs, waited);
        exp = sb.pop_front();
        checks++;
        if (!found || obs !== exp) begin
            errors++;
            $display("FAIL bad_counter found=%0d got=%h want=%h", found, obs, exp);
        end
        tick();
        r_mode = 1'b0;
        checks++;
        if (err_onehot !== 1'b1) begin
            errors++;
            $display("FAIL bad_sticky err_onehot=%b want 1", err_onehot);
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] vv;
        int   cnt;
        bit   found;
        res_t obs;
        res_t exp;
        int   waited;
        for (int v = 0; v < 8; v++) begin
            vv  = 3'(v);
            cnt = int'(vv[0]) + int'(vv[1]) + int'(vv[2]);
            start_round();
            if (v == 0) begin
                checks++;
                if (err_onehot !== 1'b0 || tally !== 2'd0) begin
                    errors++;
                    $display("FAIL start_clear err_onehot=%b tally=%0d want 0/0", err_onehot, tally);
                end
            end
            sb.push_back('{vv, 2'(cnt), (cnt >= 2), 1'b0});
            for (int i = 0; i < 3; i++) begin
                drive_ballot(2'(i), vv[i]);
                tick();
            end
            ballot_valid = 1'b0;
            collect(found, obs, waited);
            exp = sb.pop_front();
            checks++;
            if (!found || obs !== exp) begin
                errors++;
                $display("FAIL exhaustive v=%b found=%0d got=%h want=%h", vv, found, obs, exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_full_round();
        test_duplicate();
        test_timeout();
        test_bad_counter();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
